// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM state codes and
// the pipeline stall/start/ready signal values used by div_unit.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } divState_e;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        Stop              = 1'b1;
    localparam logic        NoStop            = 1'b0;
    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_unit_negate.sv
// Combinational two's-complement negate; yields the magnitude of a signed
// value when negate_i is driven by its sign bit.
module div_unit_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         negate_i,
    output logic [W-1:0] result_o
);

    assign result_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU; holds the
// pipeline with stallreq_o while busy and aborts on annul_i.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    localparam logic [CNT_W-1:0] LastStep = CNT_W'(DATA_W - 1);

    divState_e           stateQ, stateD;
    logic [CNT_W-1:0]    cntQ, cntD;
    logic [DATA_W-1:0]   dvdQ, dvdD;
    logic [DATA_W-1:0]   dvsQ, dvsD;
    logic [DATA_W-1:0]   remQ, remD;
    logic                negQuotQ, negQuotD;
    logic                negRemQ, negRemD;
    logic [2*DATA_W-1:0] resultQ, resultD;

    logic [DATA_W-1:0]   dvdMag, dvsMag;
    logic [DATA_W:0]     shifted, trial;
    logic                qBit;
    logic [DATA_W-1:0]   stepQuot, stepRem;
    logic [DATA_W-1:0]   fixQuot, fixRem;

    div_unit_negate #(.W(DATA_W)) u_dvdMag (
        .value_i  (opdata1_i),
        .negate_i (signed_i & opdata1_i[DATA_W-1]),
        .result_o (dvdMag)
    );

    div_unit_negate #(.W(DATA_W)) u_dvsMag (
        .value_i  (opdata2_i),
        .negate_i (signed_i & opdata2_i[DATA_W-1]),
        .result_o (dvsMag)
    );

    // The dividend register shifts out its MSB each step and collects quotient bits in its LSB.
    always_comb begin
        shifted  = {remQ, dvdQ[DATA_W-1]};
        trial    = shifted - {1'b0, dvsQ};
        qBit     = ~trial[DATA_W];
        stepRem  = qBit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        stepQuot = {dvdQ[DATA_W-2:0], qBit};
    end

    div_unit_negate #(.W(DATA_W)) u_fixQuot (
        .value_i  (stepQuot),
        .negate_i (negQuotQ),
        .result_o (fixQuot)
    );

    div_unit_negate #(.W(DATA_W)) u_fixRem (
        .value_i  (stepRem),
        .negate_i (negRemQ),
        .result_o (fixRem)
    );

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        dvdD     = dvdQ;
        dvsD     = dvsQ;
        remD     = remQ;
        negQuotD = negQuotQ;
        negRemD  = negRemQ;
        resultD  = resultQ;
        if (annul_i) begin
            stateD = DivFree;
            cntD   = '0;
        end else begin
            case (stateQ)
                DivFree: begin
                    if (start_i != DivStop) begin
                        if (opdata2_i == '0) begin
                            stateD = DivByZero;
                        end else begin
                            stateD   = DivOn;
                            cntD     = '0;
                            dvdD     = dvdMag;
                            dvsD     = dvsMag;
                            remD     = '0;
                            negQuotD = signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            negRemD  = signed_i & opdata1_i[DATA_W-1];
                        end
                    end
                end
                DivByZero: begin
                    stateD  = DivEnd;
                    resultD = {opdata1_i, {DATA_W{1'b1}}};
                end
                DivOn: begin
                    dvdD = stepQuot;
                    remD = stepRem;
                    cntD = cntQ + CNT_W'(1);
                    if (cntQ == LastStep) begin
                        stateD  = DivEnd;
                        cntD    = '0;
                        resultD = {fixRem, fixQuot};
                    end
                end
                DivEnd: begin
                    stateD = DivFree;
                end
                default: begin
                    stateD = DivFree;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            stateQ   <= DivFree;
            cntQ     <= '0;
            dvdQ     <= DATA_W'(ZeroWord);
            dvsQ     <= DATA_W'(ZeroWord);
            remQ     <= DATA_W'(ZeroWord);
            negQuotQ <= 1'b0;
            negRemQ  <= 1'b0;
            resultQ  <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            dvdQ     <= dvdD;
            dvsQ     <= dvsD;
            remQ     <= remD;
            negQuotQ <= negQuotD;
            negRemQ  <= negRemD;
            resultQ  <= resultD;
        end
    end

    // Stall is dropped in END so EX advances on the ready cycle.
    always_comb begin
        stallreq_o = NoStop;
        if (!annul_i && (rst != RstEnable)) begin
            case (stateQ)
                DivFree:   stallreq_o = (start_i == DivStart) ? Stop : NoStop;
                DivByZero: stallreq_o = Stop;
                DivOn:     stallreq_o = Stop;
                default:   stallreq_o = NoStop;
            endcase
        end
    end

    assign ready_o  = (stateQ == DivEnd && !annul_i) ? DivResultReady : DivResultNotReady;
    assign result_o = resultQ;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage.
- Serves RISC-V DIV/DIVU/REM/REMU.
- Requester end of the pipeline stall/flush protocol:
  - drives the EX stall request while busy;
  - obeys the pipeline flush as an annul.
- EX stage holds start/operands stable while the resulting stall vector freezes IF–EX.

Parameters:
DATA_W, 32, operand width; quotient/remainder each DATA_W bits
CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset (equal to RstEnable)
start_i  input  1  divide request from EX; held high until ready_o is seen
signed_i  input  1  1 = signed (DIV/REM), 0 = unsigned
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
annul_i  input  1  pipeline flush; aborts any operation in progress
result_o  output  2*DATA_W  {remainder, quotient}; valid while ready_o=1
ready_o  output  1  result valid, one cycle
stallreq_o  output  1  stall request to pipeline control; high = Stop

Behaviour:
- States: FREE, ZERO, ON, END. Encodings live in the shared define file.
- Reset (async, rst=1):
  - state goes to FREE, counter to 0, internal dividend/divisor/partial remainder to 0;
  - result_o = 0, ready_o = 0, stallreq_o = 0.
  - Reset mid-operation discards all work; no ready_o follows.
- annul_i=1 has priority over all transitions in every state: next state is FREE, counter is cleared, no ready_o. While annul_i=1, stallreq_o = 0.
- FREE:
  - start_i=1 and opdata2_i=0: go to ZERO.
  - start_i=1 and divisor non-zero: go to ON. Latch |dividend| and |divisor| (two's-complement magnitude when signed_i=1). Latch the sign flags. Counter = 0.
  - Otherwise stay in FREE.
- ON:
  - One restoring step per cycle: shift the partial remainder left, bring in the next dividend bit, trial-subtract the divisor. If non-negative, keep the difference and set quotient bit = 1; else quotient bit = 0.
  - Counter increments each cycle. After DATA_W steps (counter = DATA_W-1 step done), go to END.
  - Sign fixup is registered on the END transition:
    - quotient negated if signed and sign(dividend) != sign(divisor);
    - remainder negated if signed and dividend negative.
- ZERO: one cycle, then END. Result = {opdata1_i, all-ones}, regardless of signed_i (RISC-V semantics).
- END:
  - ready_o = 1 for exactly this cycle, with result_o valid.
  - Next state is FREE unconditionally.
  - EX has advanced, so start_i is low in the next cycle. If start_i is still high in FREE, it is a new request.
- Signed overflow (-2^(DATA_W-1) / -1) falls out of the magnitude datapath: quotient = 0x8000_0000, remainder = 0. No special case.
- stallreq_o (combinational from state and inputs, annul gated):
  - 1 in FREE with start_i=1;
  - 1 in ZERO;
  - 1 in ON;
  - 0 in END, so EX advances on the ready cycle.
- result_o holds its last value after END until the next result is written. Consumers must qualify it with ready_o.
- Latency, with start sampled in FREE at cycle N:
  - non-zero divisor: ready_o at cycle N+DATA_W+1 (N+33);
  - zero divisor: ready_o at cycle N+2.

Decomposition:
- Shared define file:
  - DivFree, DivByZero, DivOn, DivEnd state codes;
  - DivStart/DivStop, DivResultReady/DivResultNotReady;
  - existing Stop/NoStop, RstEnable, ZeroWord.
- No sub-module is required; the FSM and datapath stay in one file.
- An optional combinational div_negate helper (two's-complement magnitude/negate) may be factored out and shared with the multiplier.

Test Plan:
- Unsigned 100/7, start at cycle N → stallreq_o high N..N+32, ready_o only at N+33, result_o = {0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero 5/0, signed and unsigned → ready_o at N+2, result_o = {0x00000005, 0xFFFFFFFF}; stallreq_o high N..N+1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0x00000000; DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulse at N+10 during ON → stallreq_o = 0 from N+10, state FREE at N+11, no ready_o. A fresh start at N+12 completes normally at N+45.
- Async rst asserted mid-ON between clock edges → all outputs 0 immediately. After release, an idle start_i=0 keeps ready_o and stallreq_o at 0.
